// File: rtl/sc_et_counter.sv
// sc_et_counter
// Counts ones on N parallel stochastic bitstreams over a window of 2^p valid
// bits (p = min(prec, TW)), then rescales each count to TW-bit precision
// (res[j] = ones[j] << (TW - p)). A run ends at window end or on sng_done
// (taken with the coinciding valid bit). Results are returned through a
// valid/ready handshake. sng_clr/sng_en drive the stochastic number generator.
//
// Optional feature (macro SC_ET_THRESH_EN): threshold early termination on
// channel 0. It adds the input thresh (sampled on start) and the registered
// output decision.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, prec       begin run (IDLE only), log2 window length (clamped to TW)
//   sng_clr, sng_en   SNG restart pulse, SNG advance enable (high in RUN)
//   x, x_valid        stream bits (one per channel), bit-valid qualifier
//   sng_done          SNG overflow; the coinciding valid bit is the last one
//   busy              high in RUN and DONE
//   res, len          scaled ones counts (channel j at [j*(TW+1) +: TW+1]),
//                     number of valid bits consumed
//   res_valid/ready   result handshake
//   thresh, decision  (SC_ET_THRESH_EN only) threshold, early decision
module sc_et_counter #(
    parameter int TW = 8,
    parameter int N  = 2,
    parameter int PW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PW-1:0]         prec,
    output logic                  sng_clr,
    output logic                  sng_en,
    input  logic [N-1:0]          x,
    input  logic                  x_valid,
    input  logic                  sng_done,
    output logic                  busy,
    output logic [N*(TW+1)-1:0]   res,
    output logic [TW:0]           len,
    output logic                  res_valid,
    input  logic                  res_ready
`ifdef SC_ET_THRESH_EN
    ,
    input  logic [TW:0]           thresh,
    output logic                  decision
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [PW-1:0] p;
    logic [TW:0]   ones [N];
    logic [TW:0]   cyc;

    logic [TW:0]   ones_n [N];
    logic [TW:0]   cyc_n;
    logic [TW:0]   win;
    logic [PW-1:0] sh;
    logic [PW-1:0] p_start;
    logic          at_end;
    logic          et_fire;
    logic          et_ge;

`ifdef SC_ET_THRESH_EN
    logic [TW:0]   thresh_q;
    logic [TW+1:0] best_case;
`endif

    always_comb begin
        p_start = (prec > PW'(TW)) ? PW'(TW) : prec;
        win     = (TW+1)'(1) << p;
        sh      = PW'(TW) - p;
        cyc_n   = cyc + (TW+1)'(1);
        for (int unsigned j = 0; j < N; j++) begin
            ones_n[j] = ones[j] + (TW+1)'(x[j]);
        end
        at_end  = (cyc_n == win);
        et_fire = 1'b0;
        et_ge   = 1'b0;
`ifdef SC_ET_THRESH_EN
        // Best case for channel 0: every remaining bit of the window is a one.
        best_case = {1'b0, ones_n[0]} + {1'b0, win - cyc_n};
        et_ge     = (ones_n[0] >= thresh_q);
        et_fire   = et_ge || (best_case < {1'b0, thresh_q});
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            p         <= '0;
            cyc       <= '0;
            for (int unsigned j = 0; j < N; j++) ones[j] <= '0;
            sng_clr   <= 1'b0;
            sng_en    <= 1'b0;
            busy      <= 1'b0;
            res       <= '0;
            len       <= '0;
            res_valid <= 1'b0;
`ifdef SC_ET_THRESH_EN
            thresh_q  <= '0;
            decision  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sng_clr <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        p       <= p_start;
                        cyc     <= '0;
                        for (int unsigned j = 0; j < N; j++) ones[j] <= '0;
                        sng_clr <= 1'b1;
                        sng_en  <= 1'b1;
                        busy    <= 1'b1;
`ifdef SC_ET_THRESH_EN
                        thresh_q <= thresh;
`endif
                    end
                end
                RUN: begin
                    sng_clr <= 1'b0;
                    if (x_valid) begin
                        cyc <= cyc_n;
                        for (int unsigned j = 0; j < N; j++) ones[j] <= ones_n[j];
                        if (at_end || sng_done || et_fire) begin
                            state     <= DONE;
                            sng_en    <= 1'b0;
                            res_valid <= 1'b1;
                            len       <= cyc_n;
                            for (int unsigned j = 0; j < N; j++) begin
                                res[j*(TW+1) +: TW+1] <= ones_n[j] << sh;
                            end
`ifdef SC_ET_THRESH_EN
                            decision <= et_ge;
`endif
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The unused-signal case for et_ge/et_fire when the feature is off.
    logic unused_ok;
    assign unused_ok = et_ge & et_fire;

endmodule

// File: doc/sc_et_counter.md
# sc_et_counter

Downstream consumer for the bit-plane-counter SNG and the stochastic logic it drives. Counts ones on N parallel stochastic bitstreams over a programmable progressive-precision window of 2^prec cycles and rescales each count to a TW-bit-precision binary value. Ends a run at window end or when the SNG signals overflow. Returns results through a valid/ready handshake and drives clear/enable back to the SNG.

## Interface
- TW, 8: full-precision width; maximum stream length 2^TW.
- N, 2: number of parallel bitstream channels.
- PW, 4: width of prec input; must satisfy 2^PW > TW.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin run; honoured only in IDLE.
- prec  in  PW  log2 of window length; values above TW are clamped to TW; sampled on accepted start.
- sng_clr  out  1  one-cycle pulse on accepted start; restarts the SNG counter.
- sng_en  out  1  high in RUN; SNG advances only when high.
- x  in  N  stream bits, one per channel.
- x_valid  in  1  x is a valid stream bit this cycle.
- sng_done  in  1  SNG overflow; final bit when coincident with x_valid.
- busy  out  1  high in RUN and DONE.
- res  out  N*(TW+1)  channel j at [j*(TW+1) +: TW+1]; scaled ones count.
- len  out  TW+1  number of valid bits consumed in the run.
- res_valid  out  1  results valid.
- res_ready  in  1  consumer accepts results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start: latch p = min(prec, TW), clear ones[j] and cyc, pulse sng_clr, go to RUN.
- RUN: on each cycle with x_valid:
  - ones[j] += x[j]; cyc += 1.
  - Go to DONE when the bit was last, i.e. the cycle where cyc+1 == 2^p, or sng_done is high, or the configured early-termination decision fires.
  - Cycles without x_valid change nothing, including a sng_done without x_valid.
- DONE:
  - res_valid high; res[j] = ones[j] << (TW − p); len = cyc.
  - On res_valid && res_ready, go to IDLE.
- start outside IDLE is ignored.
- Widths: ones and cyc are TW+1 bits. ones saturates naturally at 2^p, because cyc bounds it. The shifted result never exceeds 2^TW.
- p = 0: window length 1; res[j] = x[j] << TW.

## Timing
- Reset values: res = 0, len = 0, res_valid = 0, busy = 0, sng_clr = 0, sng_en = 0, state IDLE.
- Reset mid-run aborts immediately, with no result. Counts clear.
- start accepted at cycle t:
  - sng_clr is high during t+1; state is RUN from t+1.
  - The first bit counted is the first x_valid at or after t+1.
- The last bit is accepted at cycle t_l. res_valid and the registered res and len are presented from t_l+1.
- Latency from last bit to result is 1 cycle. All outputs are registered.
- res, len and res_valid hold stable while res_valid && !res_ready.
- Handshake at cycle t_h: IDLE from t_h+1. A new start is accepted no earlier than t_h+1.
- Full-length run at p = TW with continuous x_valid: exactly 2^TW counted cycles, and len = 2^TW.

## Configuration
- SC_ET_THRESH_EN: threshold early termination on channel 0.
- Defined:
  - Adds input thresh (TW+1), in window-count units, sampled on start.
  - Adds output decision (1, reset 0).
  - In RUN, after the ones/cyc update the run terminates as soon as either rule fires:
    - ones[0] ≥ thresh gives decision = 1.
    - ones[0] + (2^p − cyc) < thresh gives decision = 0.
  - decision is registered with res and valid with res_valid.
  - thresh = 0 terminates on the first valid bit with decision = 1.
- Undefined: no thresh or decision ports; a run ends only at window end or sng_done.

## Test plan
- TW=8, N=2, prec=4, x_valid continuous, x[0] one in every 4 cycles, x[1] = 0 → res_valid at cycle 17 after start; res[0] = 4<<4 = 64, res[1] = 0, len = 16.
- prec=12 (clamped to 8), x[0] = 1 constantly → len = 256, res[0] = 256 (full scale), no overflow.
- prec=8, x_valid toggling every other cycle, sng_done with x_valid on the 100th valid bit → len = 100, counts reflect 100 bits only.
- res_ready held low 5 cycles after res_valid, and start pulsed meanwhile → outputs stable, start ignored, IDLE one cycle after the handshake.
- rst asserted mid-RUN after 7 bits → all outputs 0 asynchronously. The next start gives counts from zero.
- With SC_ET_THRESH_EN, prec=4, thresh=3, x[0] all ones → terminates after 3 bits, decision = 1, len = 3. With x[0] all zeros, terminates after 14 bits, decision = 0.
